// File: rtl/btb_assoc.sv
// btb_assoc: set-associative BTB with saturating counters and tree PLRU; BTB_BYPASS_EN enables same-cycle update bypass
module btb_assoc #(
  parameter int SET_LEN  = 6,
  parameter int WAYS     = 2,
  parameter int CTR_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_query,
  input  logic [31:0] PC_update,
  input  logic [31:0] update_data,
  input  logic        update,
  input  logic        BR,
  output logic        BTB_hit,
  output logic        BTB_br,
  output logic [31:0] PC_pred
);
  localparam int SETS = 1 << SET_LEN;
  localparam int TW = 30 - SET_LEN;
  localparam int LW = $clog2(WAYS);
  localparam int PW = (WAYS > 1) ? WAYS - 1 : 1;
  localparam logic [CTR_BITS-1:0] CMAX = '1;
  localparam logic [CTR_BITS-1:0] CINIT = CTR_BITS'(1 << (CTR_BITS - 1));
  logic [WAYS-1:0]     valid_q [SETS], valid_d [SETS];
  logic [TW-1:0]       tag_q   [SETS][WAYS], tag_d [SETS][WAYS];
  logic [31:0]         tgt_q   [SETS][WAYS], tgt_d [SETS][WAYS];
  logic [CTR_BITS-1:0] ctr_q   [SETS][WAYS], ctr_d [SETS][WAYS];
  logic [PW-1:0]       plru_q  [SETS], plru_d [SETS];
  logic [SET_LEN-1:0]  ui, qi;
  logic [TW-1:0]       ut, qt;
  logic                u_hit, inv, b;
  int                  u_way, v_way, t_way, n;
  logic                vv, q_hit, q_br;
  logic [TW-1:0]       vt;
  logic [31:0]         vg, q_pred;
  logic [CTR_BITS-1:0] vc;
  logic                unused_ok;
  assign ui = PC_update[SET_LEN+1:2];
  assign ut = PC_update[31:SET_LEN+2];
  assign qi = PC_query[SET_LEN+1:2];
  assign qt = PC_query[31:SET_LEN+2];
  assign unused_ok = ^{PC_query[1:0], PC_update[1:0]};
  // training: hit lookup, victim choice, counter/target/PLRU next state
  always_comb begin
    valid_d = valid_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    ctr_d = ctr_q;
    plru_d = plru_q;
    u_hit = 1'b0;
    u_way = 0;
    inv = 1'b0;
    v_way = 0;
    n = 0;
    b = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[ui][w] && tag_q[ui][w] == ut) begin
        u_hit = 1'b1;
        u_way = w;
      end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[ui][w]) begin
        inv = 1'b1;
        v_way = w;
      end
    if (!inv) begin
      for (int l = 0; l < LW; l++) n = 2 * n + 1 + int'(plru_q[ui][n]);
      v_way = n - (WAYS - 1);
    end
    t_way = u_hit ? u_way : v_way;
    n = 0;
    if (update && (u_hit || BR)) begin
      if (u_hit)
        ctr_d[ui][t_way] = BR ? ((ctr_q[ui][t_way] == CMAX) ? CMAX : ctr_q[ui][t_way] + 1'b1)
                              : ((ctr_q[ui][t_way] == '0) ? '0 : ctr_q[ui][t_way] - 1'b1);
      else begin
        valid_d[ui][t_way] = 1'b1;
        tag_d[ui][t_way] = ut;
        ctr_d[ui][t_way] = CINIT;
      end
      if (BR) tgt_d[ui][t_way] = update_data;
      for (int l = 0; l < LW; l++) begin
        b = t_way[LW-1-l];
        plru_d[ui][n] = ~b;
        n = 2 * n + 1 + int'(b);
      end
    end
  end
  // combinational query, optionally bypassing the in-flight update to the same entry
  always_comb begin
    q_hit = 1'b0;
    q_br = 1'b0;
    q_pred = '0;
    vv = 1'b0;
    vt = '0;
    vg = '0;
    vc = '0;
    for (int w = 0; w < WAYS; w++) begin
      vv = valid_q[qi][w];
      vt = tag_q[qi][w];
      vg = tgt_q[qi][w];
      vc = ctr_q[qi][w];
`ifdef BTB_BYPASS_EN
      if (update && PC_update[31:2] == PC_query[31:2]) begin
        vv = valid_d[qi][w];
        vt = tag_d[qi][w];
        vg = tgt_d[qi][w];
        vc = ctr_d[qi][w];
      end
`endif
      if (vv && vt == qt) begin
        q_hit = 1'b1;
        q_br = vc[CTR_BITS-1];
        q_pred = vg;
      end
    end
  end
  assign BTB_hit = q_hit & ~rst;
  assign BTB_br = q_br & ~rst;
  assign PC_pred = rst ? '0 : q_pred;
  // state registers with asynchronous clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= '{default: '0};
      tag_q <= '{default: '0};
      tgt_q <= '{default: '0};
      ctr_q <= '{default: '0};
      plru_q <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      tag_q <= tag_d;
      tgt_q <= tgt_d;
      ctr_q <= ctr_d;
      plru_q <= plru_d;
    end
endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: directed and randomized checks of btb_assoc (default parameters) against a 2-way LRU table model
module tb_btb_assoc;
  logic clk = 1'b0, rst = 1'b1, update = 1'b0, BR = 1'b0;
  logic [31:0] PC_query = '0, PC_update = '0, update_data = '0;
  logic BTB_hit, BTB_br;
  logic [31:0] PC_pred;
  int n_assert = 0, n_fail = 0;
  always #5 clk = ~clk;
  btb_assoc dut (
    .clk(clk), .rst(rst), .PC_query(PC_query), .PC_update(PC_update),
    .update_data(update_data), .update(update), .BR(BR),
    .BTB_hit(BTB_hit), .BTB_br(BTB_br), .PC_pred(PC_pred)
  );
  typedef struct {bit v; bit [23:0] tag; bit [31:0] tgt; int ctr;} ent_t;
  ent_t m[64][2];
  int mru[64];
  function automatic void mreset();
    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 2; j++) begin
        m[i][j].v = 0; m[i][j].tag = 0; m[i][j].tgt = 0; m[i][j].ctr = 0;
      end
      mru[i] = 1;
    end
  endfunction
  function automatic void mlook(input bit [31:0] pc, output bit h, output bit br, output bit [31:0] p);
    h = 0; br = 0; p = 0;
    for (int j = 0; j < 2; j++)
      if (m[pc[7:2]][j].v && m[pc[7:2]][j].tag == pc[31:8]) begin
        h = 1; br = m[pc[7:2]][j].ctr >= 2; p = m[pc[7:2]][j].tgt;
      end
  endfunction
  function automatic void mupd(input bit [31:0] pc, input bit br, input bit [31:0] d);
    int i = int'(pc[7:2]);
    int w = -1;
    for (int j = 0; j < 2; j++) if (m[i][j].v && m[i][j].tag == pc[31:8]) w = j;
    if (w >= 0) begin
      if (br) begin m[i][w].tgt = d; m[i][w].ctr = (m[i][w].ctr < 3) ? m[i][w].ctr + 1 : 3; end
      else m[i][w].ctr = (m[i][w].ctr > 0) ? m[i][w].ctr - 1 : 0;
      mru[i] = w;
    end else if (br) begin
      w = !m[i][0].v ? 0 : !m[i][1].v ? 1 : 1 - mru[i];
      m[i][w].v = 1; m[i][w].tag = pc[31:8]; m[i][w].tgt = d; m[i][w].ctr = 2;
      mru[i] = w;
    end
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk3(input string tag, input bit eh, input bit eb, input logic [31:0] ep);
    chk({tag, " hit"}, 32'(BTB_hit), 32'(eh));
    chk({tag, " br"}, 32'(BTB_br), 32'(eb));
    chk({tag, " pred"}, PC_pred, ep);
  endtask
  task automatic probe(input string tag, input logic [31:0] pq, input bit eh, input bit eb, input logic [31:0] ep);
    update = 1'b0; PC_query = pq;
    #1 chk3(tag, eh, eb, ep);
  endtask
  task automatic tick(input bit u, input logic [31:0] pu, input bit b, input logic [31:0] d, input logic [31:0] pq);
    bit eh, eb;
    bit [31:0] ep;
    update = u; PC_update = pu; BR = b; update_data = d; PC_query = pq;
    @(negedge clk);
    mlook(pq, eh, eb, ep);
    chk3("model", eh, eb, ep);
    @(posedge clk);
    if (u) mupd(pu, b, d);
    #1;
  endtask
  initial begin
    mreset();
    PC_query = 32'h1000;
    #12 chk3("in reset", 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    probe("post reset", 32'h1000, 0, 0, 0);
    tick(1, 32'h1000, 1, 32'h2000, 32'h0);
    probe("alloc", 32'h1000, 1, 1, 32'h2000);
    tick(1, 32'h1000, 0, 32'h9999, 32'h0);
    probe("dec1", 32'h1000, 1, 0, 32'h2000);
    tick(1, 32'h1000, 0, 32'h9999, 32'h0);
    probe("dec0", 32'h1000, 1, 0, 32'h2000);
    for (int k = 0; k < 4; k++) tick(1, 32'h1000, 1, 32'h2000, 32'h1000);
    tick(1, 32'h1000, 0, 32'h0, 32'h1000);
    probe("hyst", 32'h1000, 1, 1, 32'h2000);
    tick(1, 32'h3000, 0, 32'h7777, 32'h1000);
    probe("no alloc nt", 32'h3000, 0, 0, 0);
    tick(1, 32'h11000, 1, 32'hA000, 32'h1000);
    probe("way0 kept", 32'h1000, 1, 1, 32'h2000);
    probe("way1 alloc", 32'h11000, 1, 1, 32'hA000);
    tick(1, 32'h1000, 1, 32'h2000, 32'h11000);
    tick(1, 32'h21000, 1, 32'hB000, 32'h1000);
    probe("evicted", 32'h11000, 0, 0, 0);
    probe("mru kept", 32'h1000, 1, 1, 32'h2000);
    probe("replaced", 32'h21000, 1, 1, 32'hB000);
    update = 1'b1; PC_update = 32'h4000; BR = 1'b1; update_data = 32'h5000; PC_query = 32'h4000;
`ifdef BTB_BYPASS_EN
    #1 chk3("same cycle", 1, 1, 32'h5000);
`else
    #1 chk3("same cycle", 0, 0, 0);
`endif
    @(posedge clk);
    mupd(32'h4000, 1, 32'h5000);
    #1 probe("after same cycle", 32'h4000, 1, 1, 32'h5000);
    rst = 1'b1;
    #1 chk3("async reset", 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mreset();
    probe("cleared", 32'h4000, 0, 0, 0);
    tick(1, 32'h1000, 1, 32'h2000, 32'h0);
    probe("first after reset", 32'h1000, 1, 1, 32'h2000);
    for (int k = 0; k < 400; k++) begin
      bit u, b;
      logic [31:0] pu, pq;
      u = $urandom_range(0, 3) != 0;
      b = 1'($urandom_range(0, 1));
      pu = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
      pq = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
`ifdef BTB_BYPASS_EN
      if (u && pq[31:2] == pu[31:2]) pq = pq ^ 32'h400;
`endif
      tick(u, pu, b, $urandom, pq);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
